flash_bank_responder: RTL and testbench
=======================================

# flash_bank_responder

Flash-side responder for the program address map. The map decodes the CPU address into active-low chip selects (CS0/CS1) and an active-low write-protect qualifier (WP); one instance of this block sits behind each chip select and behaves as a flash bank. It serves word reads with fixed latency and performs NOR-style programs (bits may only go 1→0) that take a fixed busy time. Programs are rejected when WP is high.

## Interface
- N, 32, address width; matches the address map.
- DATA_W, 32, data word width.
- DEPTH_LOG2, 10, log2 of words in the bank (4 KB at defaults).
- READ_LAT, 2, cycles from request accept to read ack (≥1).
- PROG_CYCLES, 8, busy cycles for a program (≥1).

Ports:
- clk  in  1  system clock; all logic on rising edge.
- RESET  in  1  synchronous, active-high reset.
- CS  in  1  active-low bank select from the address map.
- WP  in  1  active-low write qualifier from the address map; 0 = programming permitted, 1 = protected.
- req  in  1  request strobe; meaningful only when CS=0.
- we  in  1  1 = program, 0 = read; sampled with req.
- address  in  N  byte address; word index = address[DEPTH_LOG2+1:2].
- wdata  in  DATA_W  program data; sampled with req.
- rdata  out  DATA_W  read data; valid in the ack cycle of a read and held until the next read ack.
- ack  out  1  one-cycle completion pulse.
- err  out  1  one-cycle pulse coincident with ack for a rejected request.
- busy  out  1  high while a program is in progress.

## Operation
- States: IDLE, READ, PROG, RESP_ERR.
- Accept: in IDLE, req=1 and CS=0 latch we, word index, and wdata. req with CS=1, or req in any non-IDLE state, is ignored: no ack, no err, no state change. The initiator must wait for ack before issuing the next request.
- Rejection: a program with WP=1 at accept, or any request with address[1:0]≠0, goes to RESP_ERR. The memory is not modified.
- IDLE→READ: accepted read. A latency counter loads READ_LAT-1. On reaching zero, rdata updates, ack pulses, and the state returns to IDLE.
- IDLE→PROG: accepted program with WP=0. A busy counter loads PROG_CYCLES. On the final busy cycle the stored word becomes old & wdata. The state then returns to IDLE and ack pulses.
- RESP_ERR: ack=1 and err=1 for one cycle, then IDLE.
- CS or WP changing after accept has no effect; the latched operation completes.
- Out-of-range upper address bits are not checked; chip select is the range check.
- Memory is not cleared by RESET and powers up all-ones (erased). There is no erase operation in this block.

## Timing
- RESET (sync): state=IDLE, rdata=0, ack=0, err=0, busy=0, counters=0. Memory is untouched.
- RESET during PROG: the program is aborted. If the commit edge has not occurred, the word is unchanged. No ack is issued.
- Accept cycle T: read ack at T+READ_LAT.
- Program: busy=1 for cycles T+1…T+PROG_CYCLES, write commits at the end of T+PROG_CYCLES, and ack pulses at T+PROG_CYCLES+1 with busy=0.
- Rejection: ack=err=1 at T+1.
- Back-to-back: the earliest next accept is the ack cycle itself. ack and a new accept in the same cycle are legal.
- Read after program to the same word returns the committed value.

## Structure
- Package flash_pkg holds:
  - the state enum;
  - default READ_LAT and PROG_CYCLES;
  - ERASED_WORD = all ones.
- Sub-module flash_word_array: single-port synchronous RAM with 1-cycle read, write enable, and all-ones initialization. The responder adds READ_LAT-1 cycles of control delay around it. The program read-modify-write uses the array's read port during PROG.

## Test plan
- Read after power-up: CS=0, req, we=0, address=0x10 → ack at T+2, rdata=0xFFFF_FFFF, err=0.
- Program then read: wdata=0x1234_5678 to 0x20 with WP=0 → busy for 8 cycles, ack at T+9. Reading back gives 0x1234_5678. A second program of 0xFFFF_00FF to the same word reads back 0x1234_0078.
- Protection: program with WP=1 → ack+err at T+1, busy stays 0, and a read returns the old word. Misaligned address 0x22 → ack+err.
- Ignored requests: req with CS=1 → no ack for 20 cycles. req during PROG busy → ignored, and only the original ack appears.
- RESET at T+4 of a program → busy=0, ack never fires, and the word reads back unchanged. CS deasserted mid-read → ack still at T+2.
- Back-to-back: new read accepted in the ack cycle of the previous read → second ack exactly READ_LAT later, with correct rdata for both.

Source files
------------

// File: rtl/flash_bank_responder_pkg.sv
// Shared types and defaults for the flash bank responder.
//   state_t      : responder FSM states
//   cnt_t        : latency / busy counter type
//   DEFAULT_*    : default read latency and program busy time
//   ERASED_WORD  : contents of an erased (never programmed) word
package flash_pkg;

  typedef enum logic [1:0] {
    IDLE,
    READ,
    PROG,
    RESP_ERR
  } state_t;

  typedef logic [15:0] cnt_t;

  localparam int unsigned DEFAULT_READ_LAT    = 2;
  localparam int unsigned DEFAULT_PROG_CYCLES = 8;

  localparam logic [31:0] ERASED_WORD = '1;

endpackage

// File: rtl/flash_bank_responder_if.sv
// Bus between the address map (master) and one flash bank (slave).
//   CS, WP   : active-low bank select / write qualifier
//   req, we  : request strobe and program/read select
//   address  : byte address, wdata: program data
//   rdata    : read data, ack/err: completion pulses, busy: program active
interface flash_bank_responder_if #(
  parameter int unsigned N      = 32,
  parameter int unsigned DATA_W = 32
) ();

  logic              CS;
  logic              WP;
  logic              req;
  logic              we;
  logic [N-1:0]      address;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W-1:0] rdata;
  logic              ack;
  logic              err;
  logic              busy;

  modport master (
    output CS, WP, req, we, address, wdata,
    input  rdata, ack, err, busy
  );

  modport slave (
    input  CS, WP, req, we, address, wdata,
    output rdata, ack, err, busy
  );

endinterface

// File: rtl/flash_bank_responder_word_array.sv
// Single-port synchronous word RAM, one-cycle read latency (read-before-write).
// Contents power up erased (all ones) and are never reset.
//   clk   : clock
//   we    : write enable
//   addr  : word index
//   wdata : write data
//   rdata : registered read data of addr from the previous edge
module flash_word_array #(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned DEPTH_LOG2 = 10
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [DEPTH_LOG2-1:0] addr,
  input  logic [DATA_W-1:0]     wdata,
  output logic [DATA_W-1:0]     rdata
);

  logic [DATA_W-1:0] mem [2**DEPTH_LOG2] = '{default: '1};

  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
    rdata <= mem[addr];
  end

endmodule

// File: rtl/flash_bank_responder.sv
// Flash bank responder: fixed-latency word reads and NOR-style programs
// (stored word becomes old & wdata) with a fixed busy time.
//   clk   : clock, rising edge
//   RESET : synchronous active-high reset (memory contents preserved)
//   bus   : slave side of flash_bank_responder_if
module flash_bank_responder
  import flash_pkg::*;
#(
  parameter int unsigned N           = 32,
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned DEPTH_LOG2  = 10,
  parameter int unsigned READ_LAT    = DEFAULT_READ_LAT,
  parameter int unsigned PROG_CYCLES = DEFAULT_PROG_CYCLES
) (
  input  logic                   clk,
  input  logic                   RESET,
  flash_bank_responder_if.slave  bus
);

  localparam cnt_t READ_LOAD = cnt_t'(READ_LAT - 1);
  localparam cnt_t PROG_LOAD = cnt_t'(PROG_CYCLES);

  state_t                state_q, state_d;
  cnt_t                  cnt_q, cnt_d;
  logic [DEPTH_LOG2-1:0] idx_q;
  logic [DEPTH_LOG2-1:0] in_idx;
  logic [DEPTH_LOG2-1:0] ram_addr;
  logic [DATA_W-1:0]     wdata_q;
  logic [DATA_W-1:0]     rdata_q;
  logic [DATA_W-1:0]     ram_q;
  logic                  ready;
  logic                  accept;
  logic                  read_done;
  logic                  commit;
  logic                  ram_we;
  logic                  unused_addr_hi;

  assign in_idx         = bus.address[DEPTH_LOG2+1:2];
  assign unused_addr_hi = ^bus.address[N-1:DEPTH_LOG2+2];

  // Completion cycles (cnt == 0 in READ/PROG, and RESP_ERR) are also accept
  // cycles so that a new request can be taken in the same cycle as ack.
  // PROG runs one extra cycle at cnt == 0 to produce the ack after busy drops.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    ready     = 1'b0;
    read_done = 1'b0;
    commit    = 1'b0;
    bus.ack   = 1'b0;
    bus.err   = 1'b0;
    bus.busy  = 1'b0;
    case (state_q)
      IDLE: ready = 1'b1;
      READ: begin
        if (cnt_q == '0) begin
          bus.ack   = 1'b1;
          read_done = 1'b1;
          ready     = 1'b1;
          state_d   = IDLE;
        end else begin
          cnt_d = cnt_q - cnt_t'(1);
        end
      end
      PROG: begin
        if (cnt_q == '0) begin
          bus.ack = 1'b1;
          ready   = 1'b1;
          state_d = IDLE;
        end else begin
          bus.busy = 1'b1;
          commit   = (cnt_q == cnt_t'(1));
          cnt_d    = cnt_q - cnt_t'(1);
        end
      end
      RESP_ERR: begin
        bus.ack = 1'b1;
        bus.err = 1'b1;
        ready   = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    accept = ready && bus.req && !bus.CS;
    if (accept) begin
      if ((bus.address[1:0] != 2'b00) || (bus.we && bus.WP)) begin
        state_d = RESP_ERR;
        cnt_d   = '0;
      end else if (bus.we) begin
        state_d = PROG;
        cnt_d   = PROG_LOAD;
      end else begin
        state_d = READ;
        cnt_d   = READ_LOAD;
      end
    end
  end

  // The array is addressed from the bus while a request may be accepted so
  // its registered output already holds the word in the first READ/PROG cycle.
  assign ram_addr = ready ? in_idx : idx_q;
  assign ram_we   = commit && !RESET;

  flash_word_array #(
    .DATA_W     (DATA_W),
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_array (
    .clk   (clk),
    .we    (ram_we),
    .addr  (ram_addr),
    .wdata (ram_q & wdata_q),
    .rdata (ram_q)
  );

  assign bus.rdata = read_done ? ram_q : rdata_q;

  always_ff @(posedge clk) begin
    if (RESET) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        idx_q   <= in_idx;
        wdata_q <= bus.wdata;
      end
      if (read_done) begin
        rdata_q <= ram_q;
      end
    end
  end

endmodule

// File: tb/tb_flash_bank_responder.sv
// Directed self-checking bench for flash_bank_responder (defaults:
// READ_LAT=2, PROG_CYCLES=8). Outputs are sampled 1 ns after each rising edge.
module tb_flash_bank_responder;

  logic clk = 1'b0;
  logic RESET;
  int   vectors = 0;
  int   miscompares = 0;

  always #5 clk = ~clk;

  flash_bank_responder_if #(.N(32), .DATA_W(32)) bus ();

  flash_bank_responder #(
    .N           (32),
    .DATA_W      (32),
    .DEPTH_LOG2  (10),
    .READ_LAT    (2),
    .PROG_CYCLES (8)
  ) dut (
    .clk   (clk),
    .RESET (RESET),
    .bus   (bus)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic idle_bus();
    bus.CS = 1'b0; bus.WP = 1'b0; bus.req = 1'b0; bus.we = 1'b0;
    bus.address = '0; bus.wdata = '0;
  endtask

  // Read accepted at T; ack expected at T+2 only.
  task automatic do_read(input string tag, input logic [31:0] addr, input logic [31:0] exp);
    bus.req = 1'b1; bus.we = 1'b0; bus.address = addr;
    tick();
    bus.req = 1'b0;
    chk({tag, "_ack_t1"}, 32'(bus.ack), 32'd0);
    tick();
    chk({tag, "_ack_t2"}, 32'(bus.ack), 32'd1);
    chk({tag, "_err"}, 32'(bus.err), 32'd0);
    chk({tag, "_rdata"}, bus.rdata, exp);
    tick();
  endtask

  // Program accepted at T; busy over T+1..T+8, ack at T+9.
  task automatic do_prog(input string tag, input logic [31:0] addr, input logic [31:0] data);
    bus.req = 1'b1; bus.we = 1'b1; bus.WP = 1'b0; bus.address = addr; bus.wdata = data;
    tick();
    bus.req = 1'b0; bus.we = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      chk({tag, "_busy"}, 32'(bus.busy), 32'd1);
      chk({tag, "_noack"}, 32'(bus.ack), 32'd0);
      tick();
    end
    chk({tag, "_ack"}, 32'(bus.ack), 32'd1);
    chk({tag, "_busy_end"}, 32'(bus.busy), 32'd0);
    chk({tag, "_err"}, 32'(bus.err), 32'd0);
    tick();
  endtask

  initial begin
    int acks;
    int ack_at;

    idle_bus();
    RESET = 1'b1;
    repeat (3) tick();
    RESET = 1'b0;
    chk("rst_ack", 32'(bus.ack), 32'd0);
    chk("rst_err", 32'(bus.err), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_rdata", bus.rdata, 32'd0);

    do_read("pwrup_rd", 32'h10, flash_pkg::ERASED_WORD);

    do_prog("prog1", 32'h20, 32'h1234_5678);
    do_read("rd1", 32'h20, 32'h1234_5678);
    do_prog("prog2", 32'h20, 32'hFFFF_00FF);
    do_read("rd2", 32'h20, 32'h1234_0078);

    // Write-protected program is rejected one cycle after accept.
    bus.req = 1'b1; bus.we = 1'b1; bus.WP = 1'b1; bus.address = 32'h20; bus.wdata = 32'h0;
    tick();
    bus.req = 1'b0; bus.we = 1'b0; bus.WP = 1'b0;
    chk("wp_ack", 32'(bus.ack), 32'd1);
    chk("wp_err", 32'(bus.err), 32'd1);
    chk("wp_busy", 32'(bus.busy), 32'd0);
    tick();
    chk("wp_ack_end", 32'(bus.ack), 32'd0);
    do_read("wp_rd", 32'h20, 32'h1234_0078);

    // Misaligned read.
    bus.req = 1'b1; bus.address = 32'h22;
    tick();
    bus.req = 1'b0;
    chk("mis_ack", 32'(bus.ack), 32'd1);
    chk("mis_err", 32'(bus.err), 32'd1);
    tick();

    // Requests while deselected are ignored.
    bus.CS = 1'b1; bus.req = 1'b1; bus.address = 32'h10;
    acks = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (bus.ack) acks++;
    end
    bus.req = 1'b0; bus.CS = 1'b0;
    tick();
    if (bus.ack) acks++;
    chk("cs_hi_acks", 32'(acks), 32'd0);

    // Request during program busy is ignored; one ack at T+9.
    bus.req = 1'b1; bus.we = 1'b1; bus.address = 32'h30; bus.wdata = 32'hA5A5_A5A5;
    tick();
    bus.req = 1'b0; bus.we = 1'b0;
    acks = 0; ack_at = 0;
    for (int i = 1; i <= 12; i++) begin
      if (bus.ack) begin acks++; ack_at = i; end
      if (i == 3) begin bus.req = 1'b1; bus.address = 32'h10; end
      if (i == 4) bus.req = 1'b0;
      tick();
    end
    chk("busy_req_acks", 32'(acks), 32'd1);
    chk("busy_req_ack_at", 32'(ack_at), 32'd9);
    do_read("busy_req_rd", 32'h30, 32'hA5A5_A5A5);

    // Reset at T+4 aborts the program.
    bus.req = 1'b1; bus.we = 1'b1; bus.address = 32'h40; bus.wdata = 32'h0;
    tick();
    bus.req = 1'b0; bus.we = 1'b0;
    tick(); tick(); tick();
    RESET = 1'b1;
    tick();
    RESET = 1'b0;
    chk("abort_busy", 32'(bus.busy), 32'd0);
    acks = 0;
    for (int i = 0; i < 12; i++) begin
      if (bus.ack) acks++;
      tick();
    end
    chk("abort_acks", 32'(acks), 32'd0);
    do_read("abort_rd", 32'h40, 32'hFFFF_FFFF);

    // Deselect mid-read: latched read still completes at T+2.
    bus.req = 1'b1; bus.address = 32'h20;
    tick();
    bus.req = 1'b0; bus.CS = 1'b1;
    tick();
    chk("csmid_ack", 32'(bus.ack), 32'd1);
    chk("csmid_rdata", bus.rdata, 32'h1234_0078);
    bus.CS = 1'b0;
    tick();

    // Back-to-back: second read accepted in the ack cycle of the first.
    bus.req = 1'b1; bus.address = 32'h20;
    tick();
    bus.req = 1'b0;
    tick();
    chk("b2b_ack1", 32'(bus.ack), 32'd1);
    chk("b2b_rdata1", bus.rdata, 32'h1234_0078);
    bus.req = 1'b1; bus.address = 32'h30;
    tick();
    bus.req = 1'b0;
    chk("b2b_gap_ack", 32'(bus.ack), 32'd0);
    chk("b2b_hold", bus.rdata, 32'h1234_0078);
    tick();
    chk("b2b_ack2", 32'(bus.ack), 32'd1);
    chk("b2b_rdata2", bus.rdata, 32'hA5A5_A5A5);
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
